// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: opcode constants used by the ID decoder and the mul/div FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_pkg;

    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/ex_muldiv_core.sv
// Iterative datapath: unsigned shift-add multiply or restoring divide, one bit per step.
// Latency: WIDTH step strobes after load; res_nxt shows the value the current step will produce.
// Backpressure: none; advances only when the controller pulses step.
module ex_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_nxt
);

    // opnd: multiplicand (shifts left) or divisor (static)
    // acc: product accumulator or partial remainder
    // shreg: multiplier (shifts right) or dividend/quotient (shifts left)
    logic [WIDTH-1:0] opnd, acc, shreg;
    logic [WIDTH-1:0] opnd_nxt, acc_nxt, shreg_nxt;
    logic [WIDTH:0]   rem_shift, diff;

    // One iteration of the selected algorithm
    always_comb begin
        opnd_nxt  = opnd;
        acc_nxt   = acc;
        shreg_nxt = shreg;
        // Remainder is always below the divisor, so one extra bit holds the shifted value
        rem_shift = {acc, shreg[WIDTH-1]};
        diff      = rem_shift - {1'b0, opnd};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_nxt   = diff[WIDTH-1:0];
                shreg_nxt = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt   = rem_shift[WIDTH-1:0];
                shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (shreg[0]) begin
                acc_nxt = acc + opnd;
            end
            opnd_nxt  = opnd << 1;
            shreg_nxt = shreg >> 1;
        end
        res_nxt = is_div ? shreg_nxt : acc_nxt;
    end

    // Operand load on accept, then one update per step strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            opnd  <= '0;
            acc   <= '0;
            shreg <= '0;
        end else if (load) begin
            opnd  <= b;
            acc   <= '0;
            shreg <= a;
        end else if (step) begin
            opnd  <= opnd_nxt;
            acc   <= acc_nxt;
            shreg <= shreg_nxt;
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage multi-cycle MUL/DIV sequencer: accepts from ID/EX, iterates, pulses done with the result.
// Latency: WIDTH+1 cycles from accept to done; divide by zero finishes one cycle after accept.
// Backpressure: stall freezes IF/ID/EX from the accept cycle through the last iteration; flush aborts.
module ex_muldiv_ctrl
    import ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       rw_in,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] ans,
    output logic [4:0]       rw_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             is_div_q;
    logic [4:0]       rw_lat;
    logic             go, load, step, ans_ld, ans_dz;
    logic [WIDTH-1:0] res_nxt;

    // Next state, stall/done and datapath strobes
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        ans_ld    = 1'b0;
        ans_dz    = 1'b0;
        go        = (state == IDLE) && start && ((op == OP_MUL) || (op == OP_DIV)) && !flush;
        case (state)
            IDLE: begin
                if (go) begin
                    load  = 1'b1;
                    stall = 1'b1;
                    // Zero divisor needs no iterations; result is all ones
                    if ((op == OP_DIV) && (b == '0)) begin
                        ans_dz    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                // A flush releases the pipeline immediately and discards the work
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                    step  = 1'b1;
                    if (count == LAST) begin
                        ans_ld    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // start here still names the finishing instruction, so it is not looked at
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (step) begin
            count <= count + CNT_W'(1);
        end
    end

    // Operation type and destination captured at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            is_div_q <= 1'b0;
            rw_lat   <= '0;
        end else if (load) begin
            is_div_q <= (op == OP_DIV);
            rw_lat   <= rw_in;
        end
    end

    // Result registers change only when entering DONE and hold until the next completion
    always_ff @(posedge clk) begin
        if (rst) begin
            ans    <= '0;
            rw_out <= '0;
        end else if (ans_dz) begin
            ans    <= '1;
            rw_out <= rw_in;
        end else if (ans_ld) begin
            ans    <= res_nxt;
            rw_out <= rw_lat;
        end
    end

    ex_muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .is_div  (is_div_q),
        .a       (a),
        .b       (b),
        .res_nxt (res_nxt)
    );

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: scoreboarded MUL/DIV results, stall windows, flush and reset.
// Latency: expects done WIDTH+1 cycles after accept, or one cycle for divide by zero.
// Backpressure: stimulus waits out each stall before issuing the next instruction.
module tb_ex_muldiv_ctrl;
    import ex_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [4:0]   rw_in;
    logic         flush;
    logic         stall, done;
    logic [W-1:0] ans;
    logic [4:0]   rw_out;

    typedef struct {
        logic [W-1:0] ans;
        logic [4:0]   rw;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    ex_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rw_in  (rw_in),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .ans    (ans),
        .rw_out (rw_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ans", ans, mon_e.ans);
                chk("rw_out", 32'(rw_out), 32'(mon_e.rw));
                chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            start = 1'b0;
            flush = 1'b0;
            rst   = 1'b0;
        end
    endtask

    // Issue one instruction, push its expected result, and measure the stall window
    task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [4:0] r, input bit hold, output int dcyc);
        int           n;
        int           lat;
        bit           seen;
        exp_t         e;
        logic [W-1:0] ex;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y; rw_in = r; flush = 1'b0;
        if (o == OP_MUL) ex = x * y;
        else             ex = (y == '0) ? '1 : x / y;
        lat = ((o == OP_DIV) && (y == '0)) ? 1 : W + 1;
        e.ans = ex; e.rw = r; e.cyc = cyc + lat;
        sb.push_back(e);
        n = 0; seen = 0; dcyc = -1;
        @(negedge clk);
        if (stall) n++;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(posedge clk); #1;
            if (!hold) start = 1'b0;
            @(negedge clk);
            if (done) begin
                seen = 1;
                dcyc = cyc;
                chk("stall_in_done", 32'(stall), 32'd0);
            end else if (stall) begin
                n++;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        chk("stall_cycles", 32'(n), 32'(lat));
    endtask

    initial begin
        int           d1, d2, dd;
        logic [W-1:0] ans_before;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; rw_in = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ans", ans, 32'd0);
        chk("rst_rw", 32'(rw_out), 32'd0);

        // Directed multiply and divide cases, including divide by zero
        do_op(OP_MUL, 32'd7, 32'd6, 5'd9, 0, dd);
        do_op(OP_MUL, 32'hFFFF_FFFF, 32'd2, 5'd1, 0, dd);
        do_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd2, 0, dd);
        do_op(OP_DIV, 32'd100, 32'd7, 5'd10, 0, dd);
        do_op(OP_DIV, 32'd5, 32'd9, 5'd11, 0, dd);
        do_op(OP_DIV, 32'hFFFF_FFFF, 32'd1, 5'd12, 0, dd);
        do_op(OP_DIV, 32'd123, 32'd0, 5'd3, 0, dd);

        // Random mix
        for (int i = 0; i < 6; i++) begin
            do_op((i % 2 == 0) ? OP_MUL : OP_DIV, $urandom(),
                  (i % 3 == 0) ? $urandom() : 32'($urandom_range(1, 1000)),
                  5'($urandom_range(0, 31)), 0, dd);
        end

        // Back-to-back, with start held high through the first DONE cycle
        do_op(OP_MUL, 32'd3, 32'd4, 5'd5, 1, d1);
        do_op(OP_MUL, 32'd1000, 32'd1000, 5'd6, 0, d2);
        chk("b2b_gap", 32'(d2 - d1), 32'd34);

        // Flush during CALC at T+10, new DIV at T+11
        @(posedge clk); #1;
        start = 1'b1; op = OP_MUL; a = 32'd5; b = 32'd3; rw_in = 5'd4;
        ans_before = ans;
        @(negedge clk);
        chk("flush_accept_stall", 32'(stall), 32'd1);
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_ans", ans, ans_before);
        do_op(OP_DIV, 32'd1000, 32'd10, 5'd8, 0, dd);

        // Flush in the same cycle as a qualifying start blocks acceptance
        @(posedge clk); #1;
        start = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd3; rw_in = 5'd7; flush = 1'b1;
        @(negedge clk);
        chk("start_flush_stall", 32'(stall), 32'd0);
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("start_flush_stall_next", 32'(stall), 32'd0);
        idle(40);

        // Non-MUL/DIV opcode is ignored
        @(posedge clk); #1;
        start = 1'b1; op = 4'b0000; a = 32'd1; b = 32'd2;
        @(negedge clk);
        chk("add_stall", 32'(stall), 32'd0);
        idle(40);

        // Reset in the middle of a DIV
        @(posedge clk); #1;
        start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3; rw_in = 5'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_ans", ans, 32'd0);
        chk("midrst_rw", 32'(rw_out), 32'd0);
        idle(40);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
